// File: rtl/adic_adder_pkg.sv
// Shared definitions for the ADIC adder family: slice width, controller
// state encoding and a constant log2 helper for sizing counters.
package adic_adder_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to hold values 0..n-1; never returns less than 1.
    function automatic int clog2(input int n);
        int r;
        int x;
        r = 0;
        x = n - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/add4_slice.sv
// Combinational 4-bit ripple-carry slice reused once per nibble by the
// serial adder controller.
module add4_slice
    import adic_adder_pkg::*;
(
    input  logic [SLICE_W-1:0] a4,
    input  logic [SLICE_W-1:0] b4,
    input  logic               ci,
    output logic [SLICE_W-1:0] s4,
    output logic               co
);

    logic [SLICE_W:0] c;

    // Bitwise carry chain through the slice.
    always_comb begin
        c    = '0;
        s4   = '0;
        c[0] = ci;
        for (int i = 0; i < SLICE_W; i++) begin
            s4[i]  = a4[i] ^ b4[i] ^ c[i];
            c[i+1] = (a4[i] & b4[i]) | (c[i] & (a4[i] ^ b4[i]));
        end
        co = c[SLICE_W];
    end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Serial WIDTH-bit adder: one add4_slice is time-multiplexed over the
// operand nibbles, LSB first, with the carry held in a register between
// cycles. Valid/ready on both the operand and result side.
// Optional subtract mode is enabled by defining NIBBLE_SERIAL_SUB_EN,
// which adds a 'sub' input sampled together with the operands.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for operands; in_ready high
//   RUN   | one nibble added per clock; idx counts slices done
//   DONE  | result held on sum/cout with out_valid until out_ready
module nibble_serial_adder_ctrl
    import adic_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef NIBBLE_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = clog2(NSLICE);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

    generate
        if ((WIDTH % SLICE_W) != 0 || WIDTH < 8) begin : g_bad_width
            $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 8");
        end
    endgenerate

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   res_reg;
    logic               cout_reg;
    logic               out_valid_reg;

    logic [SLICE_W-1:0] slice_s;
    logic               slice_co;
    logic [WIDTH-1:0]   b_eff;
    logic               cin_eff;

    // Subtraction stores the inverted B operand and seeds the carry with 1.
`ifdef NIBBLE_SERIAL_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? 1'b1 : cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    add4_slice u_slice (
        .a4 (a_reg[SLICE_W-1:0]),
        .b4 (b_reg[SLICE_W-1:0]),
        .ci (carry),
        .s4 (slice_s),
        .co (slice_co)
    );

    // Ready only when out of reset and idle, so it drops with rst_n at once.
    assign in_ready  = rst_n && (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = out_valid_reg;
    assign sum       = res_reg;
    assign cout      = cout_reg;

    // Controller FSM, slice counter and operand/result shift registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            carry         <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            res_reg       <= '0;
            cout_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b_eff;
                        carry <= cin_eff;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_reg   <= a_reg >> SLICE_W;
                    b_reg   <= b_reg >> SLICE_W;
                    res_reg <= {slice_s, res_reg[WIDTH-1:SLICE_W]};
                    carry   <= slice_co;
                    idx     <= idx + 1'b1;
                    if (idx == IDX_LAST) begin
                        state         <= DONE;
                        out_valid_reg <= 1'b1;
                        cout_reg      <= slice_co;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl at WIDTH=16.
module tb_nibble_serial_adder_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        busy;

    int n_checks;
    int n_fail;

    nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef NIBBLE_SERIAL_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present operands at a falling edge, let the next rising edge accept
    // them, and return at the falling edge after the accept.
    task automatic start_txn(input logic [15:0] ta, input logic [15:0] tb_v,
                             input logic tc, input logic ts);
        a        = ta;
        b        = tb_v;
        cin      = tc;
        sub      = ts;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid, busy, cout, sum} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b ov=%b busy=%b cout=%b sum=%h, want all 0",
                     in_ready, out_valid, busy, cout, sum);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_basic;
        start_txn(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            n_checks++;
            if (out_valid !== (k == 5 ? 1'b1 : 1'b0) && k == 1) begin
                n_fail++;
                $display("FAIL basic_latency: edge %0d out_valid=%b want 0", k - 1, out_valid);
            end
            n_checks++;
            if (busy !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_busy: edge %0d busy=%b rdy=%b want 1/0", k - 1, busy, in_ready);
            end
            @(negedge clk);
            n_checks++;
            if (out_valid !== (k == 4)) begin
                n_fail++;
                $display("FAIL basic_latency: edge %0d out_valid=%b want %b", k, out_valid, (k == 4));
            end
        end
        n_checks++;
        if (sum !== 16'h0000 || cout !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_result: got sum=%h cout=%b want 0000/1", sum, cout);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_release: got ov=%b rdy=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_hold;
        start_txn(16'h1234, 16'h4321, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (out_valid !== 1'b1 || sum !== 16'h5556 || cout !== 1'b0 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_stable: cycle %0d ov=%b sum=%h cout=%b rdy=%b want 1/5556/0/0",
                         k, out_valid, sum, cout, in_ready);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_release: got ov=%b rdy=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_ignore_inputs;
        start_txn(16'h1111, 16'h2222, 1'b0, 1'b0);
        a        = 16'hAAAA;
        b        = 16'hAAAA;
        cin      = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || sum !== 16'h3333 || cout !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_result: got ov=%b sum=%h cout=%b want 1/3333/0", out_valid, sum, cout);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_no_second: got busy=%b rdy=%b ov=%b want 0/1/0", busy, in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_run;
        start_txn(16'h1234, 16'h1111, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, out_valid, busy, cout, sum} !== 20'h0) begin
            n_fail++;
            $display("FAIL midrun_reset: got rdy=%b ov=%b busy=%b cout=%b sum=%h want all 0",
                     in_ready, out_valid, busy, cout, sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_txn(16'h00FF, 16'h0001, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || sum !== 16'h0100 || cout !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_after: got ov=%b sum=%h cout=%b want 1/0100/0", out_valid, sum, cout);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [16:0] expq[$];
        logic [16:0] exp_v;
        int issued;
        int got;
        int cyc;
        issued = 0;
        got    = 0;
        cyc    = 0;
        sub    = 1'b0;
        while (got < 100 && cyc < 5000) begin
            if (issued < 100 && $urandom_range(3) != 0) begin
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            a         = 16'($urandom);
            b         = 16'($urandom);
            cin       = 1'($urandom_range(1));
            out_ready = 1'($urandom_range(1));
            #1;
            if (in_valid && in_ready) begin
                expq.push_back({1'b0, a} + {1'b0, b} + {16'h0, cin});
                issued++;
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (expq.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra: result %h with no pending operands", sum);
                end else begin
                    exp_v = expq.pop_front();
                    if ({cout, sum} !== exp_v) begin
                        n_fail++;
                        $display("FAIL b2b_result: #%0d got %b_%h want %b_%h",
                                 got, cout, sum, exp_v[16], exp_v[15:0]);
                    end
                end
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (got != 100 || issued != 100 || expq.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_count: issued=%0d results=%0d pending=%0d want 100/100/0",
                     issued, got, expq.size());
        end
    endtask

`ifdef NIBBLE_SERIAL_SUB_EN
    task automatic test_sub;
        start_txn(16'h0005, 16'h0007, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || sum !== 16'hFFFE || cout !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_borrow: got ov=%b sum=%h cout=%b want 1/FFFE/0", out_valid, sum, cout);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        start_txn(16'h0007, 16'h0005, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || sum !== 16'h0002 || cout !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_noborrow: got ov=%b sum=%h cout=%b want 1/0002/1", out_valid, sum, cout);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        sub = 1'b0;
    endtask
`endif

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        test_reset();
        test_basic();
        test_hold();
        test_ignore_inputs();
        test_reset_mid_run();
        test_back_to_back();
`ifdef NIBBLE_SERIAL_SUB_EN
        test_sub();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
